// File: rtl/inpdt_mac_if.sv
// Handshake bus for inpdt_mac: start/busy control, packed 4-lane operand beats
// and the signed dot-product result.
interface inpdt_mac_if;
    logic        start;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [31:0] w_in;
    logic [31:0] inpdt_R_reg;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output start, in_valid, data_in, w_in, out_ready,
        input  busy, in_ready, inpdt_R_reg, out_valid
    );

    modport slave (
        input  start, in_valid, data_in, w_in, out_ready,
        output busy, in_ready, inpdt_R_reg, out_valid
    );
endinterface

// File: rtl/inpdt_mac.sv
// Zero-point-corrected 4-lane integer dot-product MAC with a valid/ready result port.
// Optional macro INPDT_PIPE_EN registers the lane-product sum ahead of the accumulator.
module inpdt_mac #(
    parameter logic [7:0]  ZERO_DATA = 8'd128,
    parameter logic [7:0]  ZERO_W    = 8'd128,
    parameter int unsigned VEC_LEN   = 64
) (
    input logic        clk,
    input logic        rst,
    inpdt_mac_if.slave bus_io
);
    localparam int unsigned NumBeats = VEC_LEN / 4;
    localparam int unsigned CntW     = $clog2(NumBeats + 1);

    typedef enum logic [1:0] {StIdle, StAcc, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] res_q, res_d;
    logic signed [31:0] beat_sum;
    logic signed [31:0] addend;
    logic signed [8:0]  d_op [4];
    logic signed [8:0]  w_op [4];
    logic signed [17:0] prod [4];
    logic               beat_fire;
    logic               last_beat;

    assign beat_fire = (state_q == StAcc) && bus_io.in_valid;
    assign last_beat = (cnt_q == CntW'(1));

    // Operands are widened to 9-bit signed so (0 - 128) and (255 - 128) both fit.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < 4; k++) begin
            d_op[k]  = $signed({1'b0, bus_io.data_in[8*k +: 8]}) - $signed({1'b0, ZERO_DATA});
            w_op[k]  = $signed({1'b0, bus_io.w_in[8*k +: 8]}) - $signed({1'b0, ZERO_W});
            prod[k]  = d_op[k] * w_op[k];
            beat_sum = beat_sum + {{14{prod[k][17]}}, prod[k]};
        end
    end

`ifdef INPDT_PIPE_EN
    logic signed [31:0] psum_q;
    logic               psum_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
        end else begin
            psum_q     <= beat_sum;
            psum_vld_q <= beat_fire;
        end
    end

    assign addend = psum_vld_q ? psum_q : '0;
`else
    assign addend = beat_fire ? beat_sum : '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    acc_d   = '0;
                    cnt_d   = CntW'(NumBeats);
                    state_d = StAcc;
                end
            end
            StAcc: begin
                acc_d = acc_q + addend;
                if (beat_fire) begin
                    cnt_d = cnt_q - CntW'(1);
                    if (last_beat) begin
`ifdef INPDT_PIPE_EN
                        state_d = StDrain;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
            StDrain: begin
                // Retire the product sum of the final beat still held in the pipe stage.
                acc_d   = acc_q + addend;
                state_d = StDone;
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Result is captured once on DONE entry and then held through IDLE.
        if ((state_d == StDone) && (state_q != StDone)) begin
            res_d = acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign bus_io.in_ready    = (state_q == StAcc);
    assign bus_io.out_valid   = (state_q == StDone);
    assign bus_io.busy        = (state_q != StIdle);
    assign bus_io.inpdt_R_reg = res_q;
endmodule

// File: tb/tb_inpdt_mac.sv
// Self-checking bench for inpdt_mac (VEC_LEN=8): directed runs checked against a
// behavioural dot-product model every cycle, plus literal expectations.
module tb_inpdt_mac;
    localparam int unsigned VecLen = 8;
    localparam int Beats = VecLen / 4;
`ifdef INPDT_PIPE_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nfail = 0;
    bit   cmp_en = 1'b0;

    inpdt_mac_if bus ();

    inpdt_mac #(
        .ZERO_DATA(8'd128),
        .ZERO_W   (8'd128),
        .VEC_LEN  (VecLen)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 taking beats, 2 draining, 3 result offered.
    int m_phase = 0;
    int m_left  = 0;
    int m_sum   = 0;
    int m_res   = 0;

    function automatic int beat_dot(input logic [31:0] d, input logic [31:0] w);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            s += (int'(d[8*k +: 8]) - 128) * (int'(w[8*k +: 8]) - 128);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_left = 0; m_sum = 0; m_res = 0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin m_phase = 1; m_sum = 0; m_left = Beats; end
                1: if (bus.in_valid) begin
                    m_sum += beat_dot(bus.data_in, bus.w_in);
                    m_left--;
                    if (m_left == 0) begin
                        if (Lat == 1) begin m_phase = 3; m_res = m_sum; end
                        else m_phase = 2;
                    end
                end
                2: begin m_phase = 3; m_res = m_sum; end
                3: if (bus.out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
            chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 3));
            chk("busy", 32'(bus.busy), 32'(m_phase != 0));
            chk("result", bus.inpdt_R_reg, m_res);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gaps: beat pattern 1,0,0,1 with a stray start in ACC and on the DONE exit cycle.
    task automatic run(input logic [31:0] d, input logic [31:0] w, input bit gaps,
                       input int hold, input logic [31:0] exp, input string name);
        int lat;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int b = 0; b < Beats; b++) begin
            if (gaps && b == 1) begin
                bus.in_valid = 1'b0;
                bus.data_in  = 32'hFFFF_FFFF;
                bus.start    = 1'b1;
                step();
                bus.start = 1'b0;
                step();
            end
            bus.in_valid = 1'b1;
            bus.data_in  = d;
            bus.w_in     = w;
            step();
        end
        bus.in_valid = 1'b0;
        bus.data_in  = 32'h0;
        bus.w_in     = 32'h0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(Lat));
        chk({name, "_dut"}, bus.inpdt_R_reg, exp);
        chk({name, "_model"}, m_res, exp);
        repeat (hold) step();
        chk({name, "_held"}, bus.inpdt_R_reg, exp);
        bus.out_ready = 1'b1;
        if (gaps) bus.start = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk({name, "_idle"}, 32'(bus.busy), 32'd0);
        chk({name, "_kept"}, bus.inpdt_R_reg, exp);
        step();
        chk({name, "_no_restart"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.data_in = '0; bus.w_in = '0;
        rst = 1'b1;
        repeat (3) step();
        cmp_en = 1'b1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.inpdt_R_reg, 32'd0);
        rst = 1'b0;
        step();

        run(32'h8080_8080, 32'hC8C8_C8C8, 1'b0, 0, 32'd0, "zero_data");
        run(32'h8181_8181, 32'h8282_8282, 1'b0, 0, 32'h0000_0010, "plus16");
        run(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 32'hFFFE_0400, "neg_min");
        run(32'h8181_8181, 32'h8282_8282, 1'b1, 5, 32'h0000_0010, "gaps_hold");
        run(32'h0AC8_80FF, 32'h0032_4D82, 1'b0, 1, 32'd19484, "mixed");

        // Abort after the first beat; the partial sum must never surface.
        bus.start = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.data_in  = 32'h0000_0000;
        bus.w_in     = 32'hFFFF_FFFF;
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_result", bus.inpdt_R_reg, 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        // Beats offered while idle are not consumed.
        bus.in_valid = 1'b1;
        bus.data_in  = 32'h0000_0000;
        bus.w_in     = 32'hFFFF_FFFF;
        repeat (2) step();
        bus.in_valid = 1'b0;
        chk("idle_beats_ignored", 32'(bus.busy), 32'd0);
        run(32'h8181_8181, 32'h8282_8282, 1'b0, 0, 32'h0000_0010, "after_abort");

        repeat (2) step();
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/inpdt_mac.md
INPDT_MAC -- requirements
Module: inpdt_mac

Interface
REQ-001 SHALL have parameter ZERO_DATA, default 8'd128, zero point of data operands (Xt, Ht).
REQ-002 SHALL have parameter ZERO_W, default 8'd128, zero point of weight operands.
REQ-003 SHALL have parameter VEC_LEN, default 64, elements per dot product; multiple of 4, range 4..4096.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  input  1  begin a new dot product; sampled only in IDLE.
REQ-007 SHALL have port in_valid  input  1  data_in/w_in beat valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat.
REQ-009 SHALL have port data_in  input  32  four unsigned 8-bit data lanes; lane k = bits [8k+7:8k].
REQ-010 SHALL have port w_in  input  32  four unsigned 8-bit weight lanes, same packing.
REQ-011 SHALL have port inpdt_R_reg  output  32  signed dot-product result fed to the BQT requantizer.
REQ-012 SHALL have port out_valid  output  1  inpdt_R_reg holds a completed result.
REQ-013 SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DRAIN, DONE.
REQ-016 In IDLE, start=1 SHALL clear the accumulator, load the beat counter with VEC_LEN/4, and move to ACC.
REQ-017 in_ready SHALL be 1 only in ACC; a beat is accepted when in_valid and in_ready are both 1.
REQ-018 Per accepted beat, the accumulator SHALL add sum over k=0..3 of (data lane k - ZERO_DATA) * (w lane k - ZERO_W), each operand 9-bit signed, each product 18-bit signed, sign-extended to 32 bits.
REQ-019 The accumulator SHALL be 32-bit signed, wrapping on two's-complement overflow.
REQ-020 Gaps (in_valid=0 in ACC) SHALL leave the accumulator and counter unchanged.
REQ-021 After the last beat is accepted, the FSM SHALL go to DONE the next cycle, or to DRAIN when INPDT_PIPE_EN is defined.
REQ-022 DRAIN SHALL last exactly one cycle, then go to DONE.
REQ-023 In DONE, out_valid SHALL be 1 and inpdt_R_reg SHALL equal the final accumulator and stay stable until out_ready=1.
REQ-024 DONE with out_ready=1 SHALL go to IDLE next cycle; out_valid SHALL drop and inpdt_R_reg SHALL hold its value.
REQ-025 start SHALL be ignored outside IDLE, including the cycle DONE exits to IDLE.
REQ-026 in_valid SHALL be ignored outside ACC; beats presented then are not consumed.

Reset
REQ-027 rst=1 SHALL force IDLE and set in_ready=0, out_valid=0, busy=0, inpdt_R_reg=0, and clear the accumulator, beat counter and any pipeline register on the next edge.
REQ-028 rst in mid-operation SHALL discard the partial sum; no out_valid SHALL follow for that operation.

Configuration
REQ-029 Macro INPDT_PIPE_EN, when defined, SHALL insert a register between the lane-product sum and the accumulator adder; the last-beat to out_valid latency becomes 2 cycles via DRAIN.
REQ-030 When INPDT_PIPE_EN is undefined, the product sum SHALL add combinationally into the accumulator; the last-beat to out_valid latency is 1 cycle and DRAIN is never entered.

Verification
REQ-031 VEC_LEN=8, all data=128, all w=200, 2 beats -> inpdt_R_reg=0, out_valid 1 cycle after the last beat (2 cycles with INPDT_PIPE_EN).
REQ-032 VEC_LEN=8, all data=129, all w=130 -> inpdt_R_reg=16 (32'h00000010).
REQ-033 VEC_LEN=8, all data=0, all w=255 -> inpdt_R_reg=-130048 (32'hFFFE0400).
REQ-034 Beats with in_valid toggling 1,0,0,1 plus start pulsed during ACC -> same result as the gapless run; the extra start has no effect.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_valid and inpdt_R_reg stable for 5 cycles; out_ready=1 -> IDLE next cycle.
REQ-036 rst asserted after beat 1 of 2 -> all outputs 0 next cycle; a new start with data=129, w=130 yields 16, with no residue from the aborted run.
